regfile_mp: RTL and testbench

- Parametrised successor of the integer register file: configurable data width and depth, and N flattened read ports with write-through bypass.
- Adds synchronous reset, an overflow status register and a pending-write scoreboard for multi-cycle (load/mul) results.
- Sits in ID stage: read ports feed operand muxes; write port is driven from WB; reserve port is driven from ID on issue of a long-latency op.

---
 rtl/regfile_mp_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 49 ++++
 rtl/regfile_mp.sv | 117 +++++++++++
 tb/tb_regfile_mp.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared register-file constants: architectural register indices and reset values.
// Imported by regfile_mp and regfile_scoreboard.
package regfile_mp_pkg;

    localparam int REG_ZERO   = 0;
    localparam int REG_GP     = 28;
    localparam int REG_SP     = 29;
    localparam int REG_ST     = 30;
    localparam int ST_OVF_BIT = 0;

    localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on reserve, cleared on write.
// Optional second clear port when REGFILE_WR2_EN is defined.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int AW  = 5,
    parameter int NRD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
`ifdef REGFILE_WR2_EN
    input  logic              clr2_en,
    input  logic [AW-1:0]     clr2_addr,
`endif
    input  logic [NRD*AW-1:0] lk_addr,
    output logic [NRD-1:0]    lk_busy
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] pending;

    // Set is applied last so a same-cycle reservation outlives the write it races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            if (clr_en)
                pending[clr_addr] <= 1'b0;
`ifdef REGFILE_WR2_EN
            if (clr2_en)
                pending[clr2_addr] <= 1'b0;
`endif
            if (set_en)
                pending[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        lk_busy = '0;
        for (int k = 0; k < NRD; k++)
            lk_busy[k] = pending[lk_addr[k*AW +: AW]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass, overflow status and scoreboard.
// Define REGFILE_WR2_EN to add a second (unchecked) write port.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int          DW      = 32,
    parameter int          AW      = 5,
    parameter int          NRD     = 2,
    parameter logic [31:0] GP_INIT = GP_INIT_DEF,
    parameter logic [31:0] SP_INIT = SP_INIT_DEF,
    parameter int          ST_REG  = REG_ST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              of_control,
    input  logic              overflow_flag,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    output logic              ovf_err
`ifdef REGFILE_WR2_EN
    ,
    input  logic              we2,
    input  logic [AW-1:0]     wr2_addr,
    input  logic [DW-1:0]     wr2_data
`endif
);

    localparam int            DEPTH = 1 << AW;
    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);
    localparam logic [AW-1:0] GP_A   = AW'(REG_GP);
    localparam logic [AW-1:0] SP_A   = AW'(REG_SP);
    localparam logic [AW-1:0] ST_A   = AW'(ST_REG);

    logic [DW-1:0] mem [DEPTH];
    logic          suppress;
    logic          wr_ok;
    logic          rsv_ok;
    logic [NRD-1:0] pend_busy;

    assign suppress = of_control && overflow_flag;
    assign wr_ok    = we && (wr_addr != ZERO_A) && !suppress;
    assign rsv_ok   = rsv_en && (rsv_addr != ZERO_A);

`ifdef REGFILE_WR2_EN
    logic wr2_ok;
    assign wr2_ok = we2 && (wr2_addr != ZERO_A);
`endif

    regfile_scoreboard #(
        .AW  (AW),
        .NRD (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (rsv_ok),
        .set_addr (rsv_addr),
        .clr_en   (wr_ok),
        .clr_addr (wr_addr),
`ifdef REGFILE_WR2_EN
        .clr2_en  (wr2_ok),
        .clr2_addr(wr2_addr),
`endif
        .lk_addr  (rd_addr),
        .lk_busy  (pend_busy)
    );

    // Port 1 bypass is checked before port 2 so it matches the write priority below.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_addr[k*AW +: AW] == ZERO_A) begin
                rd_data[k*DW +: DW] = '0;
                rd_busy[k]          = 1'b0;
            end else if (wr_ok && (wr_addr == rd_addr[k*AW +: AW])) begin
                rd_data[k*DW +: DW] = wr_data;
                rd_busy[k]          = 1'b0;
`ifdef REGFILE_WR2_EN
            end else if (wr2_ok && (wr2_addr == rd_addr[k*AW +: AW])) begin
                rd_data[k*DW +: DW] = wr2_data;
                rd_busy[k]          = 1'b0;
`endif
            end else begin
                rd_data[k*DW +: DW] = mem[rd_addr[k*AW +: AW]];
                rd_busy[k]          = pend_busy[k];
            end
        end
    end

    // Later assignments win: status bit, then port 2, then port 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            mem[GP_A] <= DW'(GP_INIT);
            mem[SP_A] <= DW'(SP_INIT);
            ovf_err   <= 1'b0;
        end else begin
            if (of_control && (wr_addr != ZERO_A))
                mem[ST_A][ST_OVF_BIT] <= overflow_flag;
`ifdef REGFILE_WR2_EN
            if (wr2_ok)
                mem[wr2_addr] <= wr2_data;
`endif
            if (wr_ok)
                mem[wr_addr] <= wr_data;
            ovf_err <= suppress && we && (wr_addr != ZERO_A);
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reset, directed vector table, randomized run against a model.
// Exercises the second write port only when REGFILE_WR2_EN is defined.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              we;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              of_control;
    logic              overflow_flag;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              ovf_err;
`ifdef REGFILE_WR2_EN
    logic              we2;
    logic [AW-1:0]     wr2_addr;
    logic [DW-1:0]     wr2_data;
`endif

    regfile_mp dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_busy      (rd_busy),
        .we           (we),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .of_control   (of_control),
        .overflow_flag(overflow_flag),
        .rsv_en       (rsv_en),
        .rsv_addr     (rsv_addr),
        .ovf_err      (ovf_err)
`ifdef REGFILE_WR2_EN
        ,
        .we2          (we2),
        .wr2_addr     (wr2_addr),
        .wr2_data     (wr2_data)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ofc;
        bit          ovf;
        bit          rsv;
        logic [4:0]  rsa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        bit          ee;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    // Reference model: architectural state as plain arrays
    logic [31:0] m_mem [32];
    bit          m_pend[32];
    bit          m_err;

    function automatic vec_t mk(bit rst_n, bit we_i, logic [4:0] wa, logic [31:0] wd,
                                bit ofc, bit ovf, bit rsv, logic [4:0] rsa,
                                logic [4:0] ra0, logic [4:0] ra1,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb, bit ee);
        vec_t v;
        v.rst_n = rst_n; v.we = we_i; v.wa = wa; v.wd = wd;
        v.ofc = ofc; v.ovf = ovf; v.rsv = rsv; v.rsa = rsa;
        v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_mem[28] = 32'h0000_1800;
        m_mem[29] = 32'h0000_2ffc;
        m_err     = 1'b0;
    endtask

    function automatic logic [31:0] model_read(vec_t v, logic [4:0] a);
        if (a == 0)
            return 32'h0;
        if (v.we && v.wa == a && !(v.ofc && v.ovf))
            return v.wd;
        return m_mem[a];
    endfunction

    function automatic bit model_busy(vec_t v, logic [4:0] a);
        if (a == 0)
            return 1'b0;
        if (v.we && v.wa == a && !(v.ofc && v.ovf))
            return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_edge(input vec_t v);
        bit sup;
        sup = v.ofc && v.ovf;
        if (!v.rst_n) begin
            model_reset();
        end else begin
            if (v.ofc && v.wa != 0)
                m_mem[30][0] = v.ovf;
            if (v.we && v.wa != 0 && !sup) begin
                m_mem[v.wa]  = v.wd;
                m_pend[v.wa] = 1'b0;
            end
            if (v.rsv && v.rsa != 0)
                m_pend[v.rsa] = 1'b1;
            m_err = sup && v.we && (v.wa != 0);
        end
    endtask

    // Driver
    task automatic drive(input vec_t v);
        rst           = v.rst_n;
        we            = v.we;
        wr_addr       = v.wa;
        wr_data       = v.wd;
        of_control    = v.ofc;
        overflow_flag = v.ovf;
        rsv_en        = v.rsv;
        rsv_addr      = v.rsa;
        rd_addr       = {v.ra1, v.ra0};
    endtask

    task automatic clock_edge(input vec_t v);
        @(posedge clk);
        model_edge(v);
        #1;
    endtask

    vec_t tbl[25];
    vec_t rv;

    initial begin
        // Reset held for two cycles
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 28, 29, 0, 0, 0, 0));
`ifdef REGFILE_WR2_EN
        we2 = 1'b0; wr2_addr = '0; wr2_data = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("reset_r28", rd_data[31:0], 32'h0000_1800);
        check("reset_r29", rd_data[63:32], 32'h0000_2ffc);
        check("reset_busy", rd_busy, 2'b00);
        check("reset_ovf_err", ovf_err, 1'b0);
        rd_addr = {5'd0, 5'd5};
        #1;
        check("reset_r5", rd_data[31:0], 32'h0);
        check("reset_r0", rd_data[63:32], 32'h0);

        //            rst we wa  wd            ofc ovf rsv rsa ra0 ra1 e0            e1            eb     ee
        tbl[0]  = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  28, 29, 32'h1800,     32'h2ffc,     2'b00, 0);
        tbl[1]  = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  5,  0,  32'h0,        32'h0,        2'b00, 0);
        tbl[2]  = mk(1, 1, 7,  32'hDEADBEEF, 0, 0, 0, 0,  7,  0,  32'hDEADBEEF, 32'h0,        2'b00, 0);
        tbl[3]  = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  7,  7,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
        tbl[4]  = mk(1, 1, 0,  32'hFFFFFFFF, 0, 0, 0, 0,  0,  7,  32'h0,        32'hDEADBEEF, 2'b00, 0);
        tbl[5]  = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  0,  7,  32'h0,        32'hDEADBEEF, 2'b00, 0);
        tbl[6]  = mk(1, 1, 9,  32'h5,        1, 1, 0, 0,  9,  30, 32'h0,        32'h0,        2'b00, 1);
        tbl[7]  = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  9,  30, 32'h0,        32'h1,        2'b00, 0);
        tbl[8]  = mk(1, 1, 9,  32'h6,        1, 0, 0, 0,  9,  30, 32'h6,        32'h1,        2'b00, 0);
        tbl[9]  = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  9,  30, 32'h6,        32'h0,        2'b00, 0);
        tbl[10] = mk(1, 0, 0,  32'h0,        0, 0, 1, 12, 12, 0,  32'h0,        32'h0,        2'b00, 0);
        tbl[11] = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  12, 12, 32'h0,        32'h0,        2'b11, 0);
        tbl[12] = mk(1, 1, 12, 32'h1234,     0, 0, 0, 0,  12, 12, 32'h1234,     32'h1234,     2'b00, 0);
        tbl[13] = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  12, 12, 32'h1234,     32'h1234,     2'b00, 0);
        tbl[14] = mk(1, 1, 12, 32'h5678,     0, 0, 1, 12, 12, 12, 32'h5678,     32'h5678,     2'b00, 0);
        tbl[15] = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  12, 12, 32'h5678,     32'h5678,     2'b11, 0);
        tbl[16] = mk(1, 1, 30, 32'hF1,       1, 0, 0, 0,  30, 9,  32'hF1,       32'h6,        2'b00, 0);
        tbl[17] = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  30, 9,  32'hF1,       32'h6,        2'b00, 0);
        tbl[18] = mk(1, 0, 5,  32'h77,       1, 0, 0, 0,  30, 5,  32'hF1,       32'h0,        2'b00, 0);
        tbl[19] = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  30, 5,  32'hF0,       32'h0,        2'b00, 0);
        tbl[20] = mk(1, 1, 3,  32'h11,       0, 0, 0, 0,  3,  12, 32'h11,       32'h5678,     2'b10, 0);
        tbl[21] = mk(1, 0, 0,  32'h0,        0, 0, 1, 3,  3,  0,  32'h11,       32'h0,        2'b00, 0);
        tbl[22] = mk(0, 1, 3,  32'h99,       0, 0, 0, 0,  3,  12, 32'h99,       32'h5678,     2'b11, 0);
        tbl[23] = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  3,  12, 32'h0,        32'h0,        2'b00, 0);
        tbl[24] = mk(1, 0, 0,  32'h0,        0, 0, 0, 0,  28, 30, 32'h1800,     32'h0,        2'b00, 0);
        // r3 is bypassed (busy 0) and r12 is still pending during the reset vector
        tbl[22].eb = 2'b10;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i]);
            #1;
            exp_q.push_back(tbl[i].e0);
            exp_q.push_back(tbl[i].e1);
            check($sformatf("vec%0d_rd0", i), rd_data[31:0], exp_q.pop_front());
            check($sformatf("vec%0d_rd1", i), rd_data[63:32], exp_q.pop_front());
            check($sformatf("vec%0d_busy", i), rd_busy, tbl[i].eb);
            clock_edge(tbl[i]);
            check($sformatf("vec%0d_ovf_err", i), ovf_err, tbl[i].ee);
        end

        // Back-to-back overflowed writes keep ovf_err high; a clean one drops it
        drive(mk(1, 1, 9, 32'hAA, 1, 1, 0, 0, 9, 0, 0, 0, 0, 0));
        clock_edge(mk(1, 1, 9, 32'hAA, 1, 1, 0, 0, 9, 0, 0, 0, 0, 0));
        check("seq_ovf_err_1", ovf_err, 1'b1);
        drive(mk(1, 1, 10, 32'hBB, 1, 1, 0, 0, 9, 10, 0, 0, 0, 0));
        clock_edge(mk(1, 1, 10, 32'hBB, 1, 1, 0, 0, 9, 10, 0, 0, 0, 0));
        check("seq_ovf_err_2", ovf_err, 1'b1);
        drive(mk(1, 1, 10, 32'hCC, 0, 1, 0, 0, 9, 10, 0, 0, 0, 0));
        clock_edge(mk(1, 1, 10, 32'hCC, 0, 1, 0, 0, 9, 10, 0, 0, 0, 0));
        check("seq_ovf_err_3", ovf_err, 1'b0);
        check("seq_r9_kept", rd_data[31:0], 32'h0);
        check("seq_r10_written", rd_data[63:32], 32'hCC);

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            rv = mk($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                    5'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, 5'($urandom_range(0, 15)),
                    5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 0, 0, 0, 0);
            if ($urandom_range(0, 7) == 0) rv.wa  = 5'd30;
            if ($urandom_range(0, 7) == 0) rv.ra1 = 5'd30;
            drive(rv);
            #1;
            exp_q.push_back(model_read(rv, rv.ra0));
            exp_q.push_back(model_read(rv, rv.ra1));
            check("rand_rd0", rd_data[31:0], exp_q.pop_front());
            check("rand_rd1", rd_data[63:32], exp_q.pop_front());
            check("rand_busy", rd_busy, {model_busy(rv, rv.ra1), model_busy(rv, rv.ra0)});
            clock_edge(rv);
            check("rand_ovf_err", ovf_err, m_err);
        end

`ifdef REGFILE_WR2_EN
        drive(mk(1, 1, 4, 32'hA, 0, 0, 0, 0, 4, 5, 0, 0, 0, 0));
        we2 = 1'b1; wr2_addr = 5'd4; wr2_data = 32'hB;
        #1;
        check("wr2_bypass_collide", rd_data[31:0], 32'hA);
        @(posedge clk);
        #1;
        we = 1'b0; we2 = 1'b0;
        #1;
        check("wr2_collide_r4", rd_data[31:0], 32'hA);
        we = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        we2 = 1'b1; wr2_addr = 5'd5; wr2_data = 32'h55;
        #1;
        check("wr2_bypass_p2", rd_data[63:32], 32'h55);
        @(posedge clk);
        #1;
        we = 1'b0; we2 = 1'b0;
        #1;
        check("wr2_both_r4", rd_data[31:0], 32'h44);
        check("wr2_both_r5", rd_data[63:32], 32'h55);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
